canvas_stroke_arbiter: RTL and testbench

- Shares the single canvas frame-buffer write port between two stroke requesters: port 0 is the local cursor and port 1 is the remote cursor received over the diff link.
- Arbitrates round-robin, latches the winning stroke point, and rasterises a square brush clipped to the canvas.
- Emits one pixel write per cycle under downstream back-pressure.
- Sits between user_input/comm decode and frame_buffer's BRAM write port, in the clk_pixel domain.

---
 rtl/canvas_stroke_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_canvas_stroke_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/canvas_stroke_arbiter.sv
// Round-robin arbiter between local/remote stroke points; rasterises a clipped square brush into pixel writes.
// Optional macro CANVAS_STROKE_DEDUP_EN drops repeated identical points per port.
module canvas_stroke_arbiter #(
  parameter int CANVAS_W = 320,
  parameter int CANVAS_H = 180,
  parameter int ADDR_W   = 16
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              req0_valid_in,
  output logic              req0_ready_out,
  input  logic [9:0]        req0_x_in,
  input  logic [8:0]        req0_y_in,
  input  logic [3:0]        req0_color_in,
  input  logic [2:0]        req0_sw_in,
  input  logic              req1_valid_in,
  output logic              req1_ready_out,
  input  logic [9:0]        req1_x_in,
  input  logic [8:0]        req1_y_in,
  input  logic [3:0]        req1_color_in,
  input  logic [2:0]        req1_sw_in,
  input  logic              wr_ready_in,
  output logic              wr_en_out,
  output logic [ADDR_W-1:0] wr_addr_out,
  output logic [3:0]        wr_color_out,
  output logic              busy_out,
  output logic              grant_out
);

  typedef enum logic [1:0] {IDLE, SETUP, STAMP} state_e;

  localparam logic signed [11:0] X_MAX = 12'(CANVAS_W - 1);
  localparam logic signed [11:0] Y_MAX = 12'(CANVAS_H - 1);

  state_e              state_q, state_d;
  logic [9:0]          x_q, x_d, x0_q, x0_d, x1_q, x1_d, cx_q, cx_d;
  logic [8:0]          y_q, y_d, y1_q, y1_d, cy_q, cy_d;
  logic [3:0]          color_q, color_d, wr_color_q, wr_color_d;
  logic [2:0]          sw_q, sw_d;
  logic                grant_q, grant_d, wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;

  logic                sel, hs, dup, drop;
  logic [25:0]         in_tuple;
  logic signed [11:0]  xs_lo, xs_hi, ys_lo, ys_hi;
  logic [9:0]          bx0, bx1;
  logic [8:0]          by0, by1;

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [9:0] x, input logic [8:0] y);
    return ADDR_W'(32'(y) * 32'(CANVAS_W) + 32'(x));
  endfunction

  // Both valid: the port that was not served last wins.
  assign sel      = req1_valid_in && (!req0_valid_in || !grant_q);
  assign hs       = (state_q == IDLE) && (sel ? req1_valid_in : req0_valid_in);
  assign in_tuple = sel ? {req1_x_in, req1_y_in, req1_color_in, req1_sw_in}
                        : {req0_x_in, req0_y_in, req0_color_in, req0_sw_in};

  assign req0_ready_out = (state_q == IDLE) && !sel;
  assign req1_ready_out = (state_q == IDLE) && sel;

`ifdef CANVAS_STROKE_DEDUP_EN
  logic [25:0] last0_q, last0_d, last1_q, last1_d;
  logic        last0_vld_q, last0_vld_d, last1_vld_q, last1_vld_d;

  assign dup = sel ? (last1_vld_q && (last1_q == in_tuple))
                   : (last0_vld_q && (last0_q == in_tuple));

  always_comb begin
    last0_d     = last0_q;
    last1_d     = last1_q;
    last0_vld_d = last0_vld_q;
    last1_vld_d = last1_vld_q;
    if (hs) begin
      if (sel) begin
        last1_d     = in_tuple;
        last1_vld_d = 1'b1;
      end else begin
        last0_d     = in_tuple;
        last0_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      last0_q     <= '0;
      last1_q     <= '0;
      last0_vld_q <= 1'b0;
      last1_vld_q <= 1'b0;
    end else begin
      last0_q     <= last0_d;
      last1_q     <= last1_d;
      last0_vld_q <= last0_vld_d;
      last1_vld_q <= last1_vld_d;
    end
  end
`else
  assign dup = 1'b0;
`endif

  // Clipped box, widened to signed 12 bits so x-sw and y+sw cannot wrap.
  always_comb begin
    xs_lo = $signed({2'b00, x_q}) - $signed({9'b0, sw_q});
    xs_hi = $signed({2'b00, x_q}) + $signed({9'b0, sw_q});
    ys_lo = $signed({3'b000, y_q}) - $signed({9'b0, sw_q});
    ys_hi = $signed({3'b000, y_q}) + $signed({9'b0, sw_q});
    bx0   = (xs_lo < 0) ? '0 : xs_lo[9:0];
    bx1   = (xs_hi > X_MAX) ? X_MAX[9:0] : xs_hi[9:0];
    by0   = (ys_lo < 0) ? '0 : ys_lo[8:0];
    by1   = (ys_hi > Y_MAX) ? Y_MAX[8:0] : ys_hi[8:0];
    drop  = (32'(x_q) >= 32'(CANVAS_W)) || (32'(y_q) >= 32'(CANVAS_H));
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    color_d    = color_q;
    sw_d       = sw_q;
    grant_d    = grant_q;
    x0_d       = x0_q;
    x1_d       = x1_q;
    y1_d       = y1_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    wr_en_d    = wr_en_q;
    wr_addr_d  = wr_addr_q;
    wr_color_d = wr_color_q;
    case (state_q)
      IDLE: begin
        if (hs && !dup) begin
          {x_d, y_d, color_d, sw_d} = in_tuple;
          grant_d = sel;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (drop) begin
          state_d = IDLE;
        end else begin
          x0_d       = bx0;
          x1_d       = bx1;
          y1_d       = by1;
          cx_d       = bx0;
          cy_d       = by0;
          wr_en_d    = 1'b1;
          wr_addr_d  = pix_addr(bx0, by0);
          wr_color_d = color_q;
          state_d    = STAMP;
        end
      end
      STAMP: begin
        if (wr_en_q && wr_ready_in) begin
          if (cx_q == x1_q) begin
            if (cy_q == y1_q) begin
              wr_en_d = 1'b0;
              state_d = IDLE;
            end else begin
              cx_d = x0_q;
              cy_d = cy_q + 9'd1;
            end
          end else begin
            cx_d = cx_q + 10'd1;
          end
          wr_addr_d = pix_addr(cx_d, cy_d);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      color_q    <= '0;
      sw_q       <= '0;
      grant_q    <= 1'b1;
      x0_q       <= '0;
      x1_q       <= '0;
      y1_q       <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_color_q <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      color_q    <= color_d;
      sw_q       <= sw_d;
      grant_q    <= grant_d;
      x0_q       <= x0_d;
      x1_q       <= x1_d;
      y1_q       <= y1_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_color_q <= wr_color_d;
    end
  end

  assign wr_en_out    = wr_en_q;
  assign wr_addr_out  = wr_addr_q;
  assign wr_color_out = wr_color_q;
  assign busy_out     = (state_q != IDLE);
  assign grant_out    = grant_q;

endmodule

// File: tb/tb_canvas_stroke_arbiter.sv
// Directed bench for canvas_stroke_arbiter; extra section runs when CANVAS_STROKE_DEDUP_EN is defined.
module tb_canvas_stroke_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v0 = 1'b0, v1 = 1'b0, r0, r1;
  logic [9:0]  x0 = '0, x1 = '0;
  logic [8:0]  y0 = '0, y1 = '0;
  logic [3:0]  c0 = '0, c1 = '0;
  logic [2:0]  s0 = '0, s1 = '0;
  logic        wr_ready = 1'b1;
  logic        wr_en, busy, grant;
  logic [15:0] wr_addr;
  logic [3:0]  wr_color;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [15:0] q_addr[$];
  logic [3:0]  q_col[$];

  canvas_stroke_arbiter #(.CANVAS_W(320), .CANVAS_H(180), .ADDR_W(16)) dut (
    .clk_in(clk), .rst_in(rst),
    .req0_valid_in(v0), .req0_ready_out(r0), .req0_x_in(x0), .req0_y_in(y0),
    .req0_color_in(c0), .req0_sw_in(s0),
    .req1_valid_in(v1), .req1_ready_out(r1), .req1_x_in(x1), .req1_y_in(y1),
    .req1_color_in(c1), .req1_sw_in(s1),
    .wr_ready_in(wr_ready), .wr_en_out(wr_en), .wr_addr_out(wr_addr),
    .wr_color_out(wr_color), .busy_out(busy), .grant_out(grant)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (!rst && wr_en && wr_ready) begin
      q_addr.push_back(wr_addr);
      q_col.push_back(wr_color);
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag, output int n);
    n = 0;
    while (busy && n < 200) begin
      step();
      n++;
    end
    chk({tag, "_timeout"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic send(input int p, input int x, input int y, input int c, input int s);
    q_addr.delete();
    q_col.delete();
    if (p == 0) begin
      x0 = 10'(x); y0 = 9'(y); c0 = 4'(c); s0 = 3'(s); v0 = 1'b1;
      #1 chk("ready0", {31'd0, r0}, 32'd1);
    end else begin
      x1 = 10'(x); y1 = 9'(y); c1 = 4'(c); s1 = 3'(s); v1 = 1'b1;
      #1 chk("ready1", {31'd0, r1}, 32'd1);
    end
    @(posedge clk);
    #1;
    v0 = 1'b0;
    v1 = 1'b0;
  endtask

  task automatic check_box(input string tag, input int bx0, input int bx1,
                           input int by0, input int by1, input int col);
    int idx;
    idx = 0;
    chk({tag, "_count"}, q_addr.size(), (bx1 - bx0 + 1) * (by1 - by0 + 1));
    for (int y = by0; y <= by1; y++)
      for (int x = bx0; x <= bx1; x++) begin
        if (idx < q_addr.size()) begin
          chk({tag, "_addr"}, {16'd0, q_addr[idx]}, y * 320 + x);
          chk({tag, "_color"}, {28'd0, q_col[idx]}, col);
        end
        idx++;
      end
  endtask

  initial begin
    int n;
    logic [15:0] pa;
    logic        pe, pr;

    // Reset state
    step(); step();
    rst = 1'b0;
    chk("rst_wr_en", {31'd0, wr_en}, 0);
    chk("rst_addr", {16'd0, wr_addr}, 0);
    chk("rst_color", {28'd0, wr_color}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_grant", {31'd0, grant}, 1);
    chk("rst_ready1", {31'd0, r1}, 0);

    // Basic stroke with latency checks
    send(0, 100, 50, 5, 1);
    chk("t1_setup_busy", {31'd0, busy}, 1);
    chk("t1_setup_wr_en", {31'd0, wr_en}, 0);
    chk("t1_grant", {31'd0, grant}, 0);
    chk("t1_ready_off", {30'd0, r0, r1}, 0);
    step();
    chk("t1_first_en", {31'd0, wr_en}, 1);
    chk("t1_first_addr", {16'd0, wr_addr}, 49 * 320 + 99);
    wait_idle("t1", n);
    chk("t1_cycles", n, 9);
    chk("t1_end_wr_en", {31'd0, wr_en}, 0);
    check_box("t1", 99, 101, 49, 51, 5);

    // Clipped at canvas corner
    send(1, 0, 179, 9, 2);
    chk("t2_grant", {31'd0, grant}, 1);
    wait_idle("t2", n);
    check_box("t2", 0, 2, 177, 179, 9);

    // Round-robin with both held valid, first service under stall
    rst = 1'b1;
    step();
    rst = 1'b0;
    x0 = 10; y0 = 10; c0 = 1; s0 = 0;
    x1 = 20; y1 = 20; c1 = 2; s1 = 0;
    v0 = 1'b1; v1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_ready0", {31'd0, r0}, (i % 2 == 0) ? 1 : 0);
      chk("rr_ready1", {31'd0, r1}, (i % 2 == 1) ? 1 : 0);
      q_addr.delete();
      q_col.delete();
      step();
      chk("rr_grant", {31'd0, grant}, i % 2);
      if (i == 0) begin
        wr_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
          step();
          chk("stall_loser_ready", {30'd0, r0, r1}, 0);
          chk("stall_en", {31'd0, wr_en}, 1);
          chk("stall_addr", {16'd0, wr_addr}, 3210);
        end
        wr_ready = 1'b1;
      end
      wait_idle("rr", n);
      if (i % 2 == 0) check_box("rr0", 10, 10, 10, 10, 1);
      else            check_box("rr1", 20, 20, 20, 20, 2);
    end
    v0 = 1'b0;
    v1 = 1'b0;

    // Back-pressure pattern 1,0,0,1 repeating
    send(0, 50, 60, 3, 1);
    for (int i = 0; i < 100 && busy; i++) begin
      wr_ready = ((i % 4) == 0 || (i % 4) == 3);
      pa = wr_addr;
      pe = wr_en;
      pr = wr_ready;
      step();
      if (pe && !pr) begin
        chk("bp_hold_en", {31'd0, wr_en}, 1);
        chk("bp_hold_addr", {16'd0, wr_addr}, {16'd0, pa});
      end
    end
    wr_ready = 1'b1;
    chk("bp_timeout", {31'd0, busy}, 0);
    check_box("bp", 49, 51, 59, 61, 3);

    // Out-of-range point is accepted and dropped
    send(0, 400, 10, 4, 1);
    chk("oor_busy", {31'd0, busy}, 1);
    chk("oor_setup_en", {31'd0, wr_en}, 0);
    wait_idle("oor", n);
    chk("oor_cycles", n, 1);
    chk("oor_writes", q_addr.size(), 0);

    // Reset during STAMP
    send(0, 100, 100, 7, 3);
    step();
    step(); step(); step();
    chk("rs_mid_en", {31'd0, wr_en}, 1);
    chk("rs_mid_grant", {31'd0, grant}, 0);
    rst = 1'b1;
    step();
    chk("rs_wr_en", {31'd0, wr_en}, 0);
    chk("rs_grant", {31'd0, grant}, 1);
    chk("rs_busy", {31'd0, busy}, 0);
    rst = 1'b0;
    step();
    chk("rs_after_en", {31'd0, wr_en}, 0);

`ifdef CANVAS_STROKE_DEDUP_EN
    send(0, 100, 50, 5, 1);
    wait_idle("dd1", n);
    check_box("dd1", 99, 101, 49, 51, 5);
    send(0, 100, 50, 5, 1);
    chk("dd2_busy", {31'd0, busy}, 0);
    wait_idle("dd2", n);
    chk("dd2_writes", q_addr.size(), 0);
    send(0, 100, 50, 6, 1);
    wait_idle("dd3", n);
    check_box("dd3", 99, 101, 49, 51, 6);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
